// File: rtl/timer_pkg.sv
// Shared definitions for the minutes:seconds timer core.
// Holds the FSM state encoding, the 6-bit minute/second limit, the BCD
// digit width and small helpers for saturation and binary-to-BCD split.
package timer_pkg;

    localparam int unsigned MS_W  = 6;
    localparam int unsigned BCD_W = 4;

    localparam logic [MS_W-1:0] MAX_MS = 6'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
    } bcd_pair_t;

    // Clamp a switch value to the largest legal minute/second count.
    function automatic logic [MS_W-1:0] sat_ms(input logic [MS_W-1:0] v);
        return (v > MAX_MS) ? MAX_MS : v;
    endfunction

    // Split a 0..59 value into its tens and units digits.
    function automatic bcd_pair_t to_bcd(input logic [MS_W-1:0] v);
        bcd_pair_t r;
        r.tens  = BCD_W'(v / MS_W'(10));
        r.units = BCD_W'(v % MS_W'(10));
        return r;
    endfunction

endpackage

// File: rtl/mmss_timer_core_if.sv
// Control/display bundle of the timer core.
// master: drives num, setmin, setsec, dir, start, stop; reads the digits,
//         running, alarm and done.
// slave : the timer core side.
interface mmss_timer_core_if;
    import timer_pkg::*;

    logic [MS_W-1:0]  num;
    logic             setmin;
    logic             setsec;
    logic             dir;
    logic             start;
    logic             stop;
    logic [BCD_W-1:0] min1;
    logic [BCD_W-1:0] min0;
    logic [BCD_W-1:0] sec1;
    logic [BCD_W-1:0] sec0;
    logic             running;
    logic             alarm;
    logic             done;

    modport master (
        output num, setmin, setsec, dir, start, stop,
        input  min1, min0, sec1, sec0, running, alarm, done
    );

    modport slave (
        input  num, setmin, setsec, dir, start, stop,
        output min1, min0, sec1, sec0, running, alarm, done
    );

endinterface

// File: rtl/tick_gen.sv
// One-second prescaler.
// Ports: clk, reset (async active-low), en (count this cycle),
//        clr (restart the period), tick (high on the last cycle of a period
//        while enabled; the counter wraps to 0 on that cycle).
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Counter holds its value when disabled so a pause keeps the phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mmss_timer_core.sv
// Kitchen-timer timekeeping core: loads minutes/seconds from switches,
// counts up or down once per prescaler tick and raises an alarm at the end.
// Ports: clk, reset (async active-low), bus (slave side of
//        mmss_timer_core_if: load/start/stop controls in, BCD digits and
//        running/alarm/done status out, all outputs registered).
module mmss_timer_core
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    mmss_timer_core_if.slave     bus
);

    state_t          state, state_n;
    logic [MS_W-1:0] min_q, min_n;
    logic [MS_W-1:0] sec_q, sec_n;
    logic            up_q, up_n;
    logic            tick;
    logic            pre_en;
    logic            start_blocked;
    logic            start_ok;
    bcd_pair_t       min_bcd, sec_bcd;

    // A start that would finish immediately is refused.
    assign start_blocked = bus.dir ? ((min_q == MAX_MS) && (sec_q == MAX_MS))
                                   : ((min_q == '0) && (sec_q == '0));
    assign start_ok = ((state == IDLE) || (state == PAUSE)) && bus.start
                      && !bus.stop && !start_blocked;
    // Stop beats a coincident tick, so the prescaler is held that cycle too.
    assign pre_en = (state == RUN) && !bus.stop;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (pre_en),
        .clr   (start_ok),
        .tick  (tick)
    );

    // Next state and next count.
    always_comb begin
        state_n = state;
        min_n   = min_q;
        sec_n   = sec_q;
        up_n    = up_q;
        case (state)
            IDLE, PAUSE: begin
                if (bus.setmin) begin
                    min_n = sat_ms(bus.num);
                end else if (bus.setsec) begin
                    sec_n = sat_ms(bus.num);
                end
                if (start_ok) begin
                    state_n = RUN;
                    up_n    = bus.dir;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    if (up_q) begin
                        if (sec_q == MAX_MS) begin
                            sec_n = '0;
                            min_n = min_q + MS_W'(1);
                        end else begin
                            sec_n = sec_q + MS_W'(1);
                        end
                        if ((min_n == MAX_MS) && (sec_n == MAX_MS)) begin
                            state_n = ALARM;
                        end
                    end else begin
                        if (sec_q == '0) begin
                            sec_n = MAX_MS;
                            min_n = min_q - MS_W'(1);
                        end else begin
                            sec_n = sec_q - MS_W'(1);
                        end
                        if ((min_n == '0) && (sec_n == '0)) begin
                            state_n = ALARM;
                        end
                    end
                end
            end
            ALARM: begin
                if (bus.stop) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign min_bcd = to_bcd(min_n);
    assign sec_bcd = to_bcd(sec_n);

    // State, counters and outputs registered from the next-state values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            min_q       <= '0;
            sec_q       <= '0;
            up_q        <= 1'b0;
            bus.min1    <= '0;
            bus.min0    <= '0;
            bus.sec1    <= '0;
            bus.sec0    <= '0;
            bus.running <= 1'b0;
            bus.alarm   <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= state_n;
            min_q       <= min_n;
            sec_q       <= sec_n;
            up_q        <= up_n;
            bus.min1    <= min_bcd.tens;
            bus.min0    <= min_bcd.units;
            bus.sec1    <= sec_bcd.tens;
            bus.sec0    <= sec_bcd.units;
            bus.running <= (state_n == RUN);
            bus.alarm   <= (state_n == ALARM);
            bus.done    <= (state_n == ALARM) && (state != ALARM);
        end
    end

endmodule

// File: tb/tb_mmss_timer_core.sv
// Self-checking bench for mmss_timer_core with a 4-cycle tick.
module tb_mmss_timer_core;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mmss_timer_core_if bus ();

    mmss_timer_core #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (total seconds, phase in cycles)
    int m_st;      // 0 idle, 1 run, 2 pause, 3 alarm
    int m_total;   // minutes*60 + seconds
    int m_phase;   // cycles since the current period began
    bit m_up;
    bit m_done;
    int m_old;

    function automatic int sat(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_total = 0; m_phase = 0; m_up = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_st)
                0, 2: begin
                    m_old = m_total;
                    if (bus.setmin)
                        m_total = sat(int'(bus.num)) * 60 + (m_total % 60);
                    else if (bus.setsec)
                        m_total = (m_total / 60) * 60 + sat(int'(bus.num));
                    if (bus.start && !bus.stop &&
                        !(bus.dir ? (m_old == 3599) : (m_old == 0))) begin
                        m_st = 1; m_up = bus.dir; m_phase = 0;
                    end
                end
                1: begin
                    if (bus.stop) begin
                        m_st = 2;
                    end else begin
                        m_phase++;
                        if (m_phase == 4) begin
                            m_phase = 0;
                            m_total = m_total + (m_up ? 1 : -1);
                            if (m_total == (m_up ? 3599 : 0)) begin
                                m_st = 3; m_done = 1'b1;
                            end
                        end
                    end
                end
                default: if (bus.stop) m_st = 0;
            endcase
        end
    end

    function automatic logic [18:0] model_outs();
        int mi, se;
        mi = m_total / 60;
        se = m_total % 60;
        return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10),
                m_st == 1, m_st == 3, m_done};
    endfunction

    function automatic logic [18:0] dut_outs();
        return {bus.min1, bus.min0, bus.sec1, bus.sec0,
                bus.running, bus.alarm, bus.done};
    endfunction

    task automatic check(input string name, input logic [18:0] act,
                         input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got digits=%h r/a/d=%b expected digits=%h r/a/d=%b",
                     name, act[18:3], act[2:0], exp[18:3], exp[2:0]);
        end
    endtask

    // Every cycle, away from the active edge, the DUT must match the model.
    always @(negedge clk) begin
        check("model", dut_outs(), model_outs());
    end

    // ---------------- stimulus helpers
    task automatic clear_in();
        bus.setmin = 1'b0; bus.setsec = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic apply(input logic [5:0] n, input logic sm, input logic ss,
                         input logic d, input logic st, input logic sp);
        bus.num = n; bus.setmin = sm; bus.setsec = ss; bus.dir = d;
        bus.start = st; bus.stop = sp;
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [15:0] dig,
                              input logic r, input logic a, input logic d);
        check(name, dut_outs(), {dig, r, a, d});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        expect_out("reset_async", 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic [5:0]  num;
        logic        sm, ss, d, st, sp;
        logic [15:0] dig;
        logic        run, alm;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{6'd0,  0, 0, 0, 0, 0, 16'h0000, 0, 0};
        vecs[1]  = '{6'd2,  1, 0, 0, 0, 0, 16'h0200, 0, 0};
        vecs[2]  = '{6'd5,  0, 1, 0, 0, 0, 16'h0205, 0, 0};
        vecs[3]  = '{6'd63, 1, 0, 0, 0, 0, 16'h5905, 0, 0};
        vecs[4]  = '{6'd63, 0, 1, 0, 0, 0, 16'h5959, 0, 0};
        vecs[5]  = '{6'd0,  1, 1, 0, 0, 0, 16'h0059, 0, 0};
        vecs[6]  = '{6'd0,  0, 0, 0, 1, 0, 16'h0059, 1, 0};
        vecs[7]  = '{6'd9,  1, 0, 0, 0, 0, 16'h0059, 1, 0};
        vecs[8]  = '{6'd0,  0, 0, 0, 0, 1, 16'h0059, 0, 0};
        vecs[9]  = '{6'd3,  1, 0, 0, 0, 0, 16'h0359, 0, 0};
        vecs[10] = '{6'd0,  0, 0, 0, 1, 1, 16'h0359, 0, 0};
        vecs[11] = '{6'd0,  0, 0, 1, 1, 0, 16'h0359, 1, 0};
        vecs[12] = '{6'd0,  0, 0, 0, 0, 0, 16'h0359, 1, 0};
        vecs[13] = '{6'd0,  0, 0, 0, 0, 0, 16'h0359, 1, 0};
        vecs[14] = '{6'd0,  0, 0, 0, 0, 0, 16'h0359, 1, 0};
        vecs[15] = '{6'd0,  0, 0, 0, 0, 0, 16'h0400, 1, 0};
        vecs[16] = '{6'd0,  0, 0, 0, 0, 1, 16'h0400, 0, 0};
    end

    initial begin
        bus.num = '0; bus.dir = 1'b0;
        clear_in();
        do_reset();

        // Loads, saturation, priority, start/stop basics and an up carry.
        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].num, vecs[i].sm, vecs[i].ss, vecs[i].d,
                  vecs[i].st, vecs[i].sp);
            expect_out($sformatf("vec%0d", i), vecs[i].dig, vecs[i].run,
                       vecs[i].alm, 1'b0);
        end

        // Count-down wrap from 01:00 and finish at 00:00.
        do_reset();
        apply(6'd1, 1, 0, 0, 0, 0);
        apply(6'd0, 0, 0, 0, 1, 0);
        expect_out("dn_start", 16'h0100, 1, 0, 0);
        step(3);
        expect_out("dn_pre_tick", 16'h0100, 1, 0, 0);
        step(1);
        expect_out("dn_wrap", 16'h0059, 1, 0, 0);
        step(235);
        expect_out("dn_239", 16'h0001, 1, 0, 0);
        step(1);
        expect_out("dn_done", 16'h0000, 0, 1, 1);
        step(1);
        expect_out("dn_alarm_hold", 16'h0000, 0, 1, 0);
        apply(6'd0, 0, 0, 0, 0, 1);
        expect_out("alarm_ack", 16'h0000, 0, 0, 0);
        apply(6'd0, 0, 0, 0, 1, 0);
        expect_out("start_zero_down", 16'h0000, 0, 0, 0);
        step(4);
        expect_out("start_zero_stay", 16'h0000, 0, 0, 0);

        // Count-up minute carry from 00:58.
        apply(6'd58, 0, 1, 0, 0, 0);
        apply(6'd0, 0, 0, 1, 1, 0);
        step(4);
        expect_out("up_59", 16'h0059, 1, 0, 0);
        step(4);
        expect_out("up_carry", 16'h0100, 1, 0, 0);

        // Count-up finish from 59:58.
        apply(6'd0, 0, 0, 0, 0, 1);
        apply(6'd59, 1, 0, 0, 0, 0);
        apply(6'd58, 0, 1, 0, 0, 0);
        apply(6'd0, 0, 0, 1, 1, 0);
        step(4);
        expect_out("up_done", 16'h5959, 0, 1, 1);
        step(4);
        expect_out("up_alarm_8", 16'h5959, 0, 1, 0);
        apply(6'd0, 0, 0, 0, 0, 1);
        apply(6'd0, 0, 0, 1, 1, 0);
        expect_out("start_full_up", 16'h5959, 0, 0, 0);

        // Stop on the tick cycle, start+stop in PAUSE, resume period.
        apply(6'd0, 1, 0, 0, 0, 0);
        apply(6'd10, 0, 1, 0, 0, 0);
        apply(6'd0, 0, 0, 0, 1, 0);
        step(3);
        apply(6'd0, 0, 0, 0, 0, 1);
        expect_out("stop_on_tick", 16'h0010, 0, 0, 0);
        apply(6'd0, 0, 0, 0, 1, 1);
        expect_out("start_stop_pause", 16'h0010, 0, 0, 0);
        apply(6'd0, 0, 0, 0, 1, 0);
        step(3);
        expect_out("resume_full_period", 16'h0010, 1, 0, 0);
        step(1);
        expect_out("resume_tick", 16'h0009, 1, 0, 0);

        // Asynchronous reset mid-RUN.
        step(1);
        #1;
        reset = 1'b0;
        #1;
        expect_out("reset_mid_run", 16'h0000, 0, 0, 0);
        step(1);
        reset = 1'b1;

        // Randomised traffic checked against the model each cycle.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0: bus.num = 6'd0;
                1: bus.num = 6'd1;
                2: bus.num = 6'd58;
                3: bus.num = 6'd59;
                default: bus.num = 6'($urandom_range(0, 63));
            endcase
            bus.setmin = ($urandom_range(0, 7) == 0);
            bus.setsec = ($urandom_range(0, 7) == 0);
            bus.dir    = 1'($urandom_range(0, 1));
            bus.start  = ($urandom_range(0, 9) == 0);
            bus.stop   = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        clear_in();
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
